// File: rtl/uart_pkg.sv
// Shared constants, state encodings and bit-timing helpers for the UART core.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    // Never narrower than one bit so degenerate clock/baud ratios still elaborate.
    function automatic int counter_width(input int clock_freq, input int baud_rate);
        int w;
        w = $clog2(symbol_edge_time(clock_freq, baud_rate));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes serial_in, samples each bit mid-symbol and presents bytes on a valid/ready port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int SYMBOL = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = counter_width(CLOCK_FREQ, BAUD_RATE);
    localparam logic [CW-1:0] CNT_LAST    = CW'(SYMBOL - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(sample_time(CLOCK_FREQ, BAUD_RATE) - 1);
    localparam logic [2:0]    IDX_LAST    = 3'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [1:0]           sync_q;
    logic                 rx_line;
    logic                 line_prev;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [2:0]           idx;
    logic [2:0]           idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic                 stop_err;
    logic                 stop_err_next;
    logic                 byte_done;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;

    assign rx_line = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q         <= 2'b11;
            line_prev      <= 1'b1;
            state          <= RX_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            stop_err       <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], serial_in};
            line_prev      <= rx_line;
            state          <= state_next;
            cnt            <= cnt_next;
            idx            <= idx_next;
            shreg          <= shreg_next;
            stop_err       <= stop_err_next;
            data_out       <= data_next;
            data_out_valid <= valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        idx_next      = idx;
        shreg_next    = shreg;
        stop_err_next = stop_err;
        byte_done     = 1'b0;
        case (state)
            RX_IDLE: begin
                if (line_prev && !rx_line) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                // A line back at 1 by mid-start-bit was a glitch, not a frame.
                if (cnt == SAMPLE_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_line, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_LAST) begin
                        state_next = RX_STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (stop_err) begin
                    if (rx_line) begin
                        stop_err_next = 1'b0;
                        state_next    = RX_IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_line) begin
                        byte_done  = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        stop_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    // A byte finishing in the same cycle as a consume wins, keeping valid high.
    always_comb begin
        data_next  = data_out;
        valid_next = data_out_valid;
        if (data_out_valid && data_out_ready) begin
            valid_next = 1'b0;
        end
        if (byte_done) begin
            data_next  = shreg;
            valid_next = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: accepts a byte on valid&ready and shifts {stop, data, start} out LSB first.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 serial_out
);

    localparam int SYMBOL = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = counter_width(CLOCK_FREQ, BAUD_RATE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL - 1);
    localparam logic [3:0]    IDX_LAST = 4'(FRAME_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [3:0]            idx;
    logic [3:0]            idx_next;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_next;
    logic                  ready;
    logic                  ready_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '1;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            ready <= ready_next;
        end
    end

    // The line is driven straight from shreg[0]; idle and stop both leave it at 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        ready_next = ready;
        case (state)
            TX_IDLE: begin
                ready_next = 1'b1;
                if (data_in_valid && ready) begin
                    state_next = TX_SEND;
                    shreg_next = {1'b1, data_in, 1'b0};
                    cnt_next   = '0;
                    idx_next   = '0;
                    ready_next = 1'b0;
                end
            end
            TX_SEND: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (idx == IDX_LAST) begin
                        state_next = TX_IDLE;
                        shreg_next = '1;
                        ready_next = 1'b1;
                    end else begin
                        idx_next   = idx + 4'd1;
                        shreg_next = {1'b1, shreg[FRAME_BITS-1:1]};
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    assign data_in_ready = ready;
    assign serial_out    = shreg[0];

endmodule

// File: rtl/uart_core_trx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock and reset.
module uart_core_trx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);

    uart_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    uart_rx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .rst_n         (rst_n),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

endmodule

// File: tb/tb_uart_core_trx.sv
// Directed bench for uart_core_trx at a 20-clock bit period, with a TX->RX loopback mux.
`timescale 1ns/1ps
module tb_uart_core_trx;

    localparam int CLOCK_FREQ = 2_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int SYM        = 20;                  // 2_000_000 / 100_000
    localparam int HALF       = 10;                  // SYM / 2
    localparam int DONE_AT    = 3 + HALF + 9 * SYM;  // RX completion edge, in ticks after the start bit is driven

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       serial_in;
    logic       serial_out;
    logic       loop_en;
    logic       drive_line;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign serial_in = loop_en ? serial_out : drive_line;

    uart_core_trx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .serial_in     (serial_in),
        .serial_out    (serial_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int n = 0;
        while (data_in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (data_in_ready === 1'b1);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n = 0;
        while (data_out_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (data_out_valid === 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        data_in       = 8'($urandom_range(0, 255));
    endtask

    task automatic consume;
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
    endtask

    // Bit-bangs one frame on drive_line; data_out_ready is pulsed on tick ack_at (negative: never).
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int ack_at, input bit hold_low);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int j = 0; j < 10 * SYM; j++) begin
            drive_line     = frame[j / SYM];
            data_out_ready = (j == ack_at);
            tick();
        end
        data_out_ready = 1'b0;
        if (hold_low) ticks(SYM);
        drive_line = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [9:0] frame;
        logic [7:0] b;
        logic [7:0] got;
        bit         ok;
        int         bad;
        int         ready_low;
        int         t0;

        rst_n          = 1'b0;
        data_in        = 8'h00;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        loop_en        = 1'b0;
        drive_line     = 1'b1;

        // Reset state
        ticks(3);
        check("rst_ready_low", data_in_ready, 0);
        check("rst_serial_out", serial_out, 1);
        check("rst_valid", data_out_valid, 0);
        check("rst_data_out", data_out, 8'h00);
        rst_n = 1'b1;
        tick();
        check("rst_ready_after", data_in_ready, 1);

        // TX waveform for 0xA5, with a stray valid during the frame that must be ignored
        frame = {1'b1, 8'hA5, 1'b0};
        send_byte(8'hA5);
        ready_low = 0;
        for (int bi = 0; bi < 10; bi++) begin
            bad = 0;
            for (int k = 0; k < SYM; k++) begin
                if (serial_out !== frame[bi]) bad++;
                if (data_in_ready === 1'b0) ready_low++;
                if (bi == 2 && k == 5) begin
                    data_in_valid = 1'b1;
                    data_in       = 8'h00;
                end else begin
                    data_in_valid = 1'b0;
                end
                tick();
            end
            check($sformatf("tx_bit%0d", bi), bad, 0);
        end
        check("tx_ready_low_cycles", ready_low, 10 * SYM);
        check("tx_ready_back", data_in_ready, 1);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (serial_out !== 1'b1) bad++;
            tick();
        end
        check("tx_idle_high", bad, 0);

        // Loopback 0x11..0x1A with a growing consume delay
        loop_en = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            b = 8'h11 + 8'(i);
            wait_ready(12 * SYM, ok);
            check("lb_ready_wait", ok, 1);
            send_byte(b);
            exp_q.push_back(b);
            wait_valid(12 * SYM, ok);
            check("lb_valid_wait", ok, 1);
            bad = 0;
            for (int d = 0; d < i; d++) begin
                tick();
                if (data_out_valid !== 1'b1) bad++;
            end
            check("lb_valid_hold", bad, 0);
            got = exp_q.pop_front();
            check($sformatf("lb_data_%0d", i), data_out, got);
            consume();
            check("lb_valid_clear", data_out_valid, 0);
        end
        check("lb_cycle_budget", (cyc - t0) <= 10 * 11 * SYM, 1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (data_out !== 8'h1A) bad++;
        end
        check("lb_data_holds_1a", bad, 0);

        // Glitch shorter than half a bit
        wait_ready(12 * SYM, ok);
        check("glitch_ready_wait", ok, 1);
        ticks(SYM);
        loop_en    = 1'b0;
        drive_line = 1'b0;
        ticks(5);
        drive_line = 1'b1;
        bad = 0;
        for (int k = 0; k < 12 * SYM; k++) begin
            tick();
            if (data_out_valid !== 1'b0) bad++;
        end
        check("glitch_no_valid", bad, 0);
        check("glitch_data_kept", data_out, 8'h1A);

        // Framing error: stop bit 0, line held low a further bit
        drive_frame(8'h55, 1'b0, -1, 1'b1);
        ticks(2 * SYM);
        check("frame_err_no_valid", data_out_valid, 0);
        check("frame_err_data_kept", data_out, 8'h1A);

        // Receiver recovers with a clean frame
        drive_frame(8'h96, 1'b1, -1, 1'b0);
        ticks(3);
        check("recover_valid", data_out_valid, 1);
        check("recover_data", data_out, 8'h96);
        consume();
        check("recover_clear", data_out_valid, 0);

        // Overrun: two bytes, no consume
        loop_en = 1'b1;
        send_byte(8'h3C);
        wait_valid(12 * SYM, ok);
        check("ovr_first_wait", ok, 1);
        check("ovr_first_data", data_out, 8'h3C);
        wait_ready(12 * SYM, ok);
        check("ovr_ready_wait", ok, 1);
        send_byte(8'hC3);
        wait_ready(12 * SYM, ok);
        check("ovr_ready_wait2", ok, 1);
        ticks(SYM);
        check("ovr_valid", data_out_valid, 1);
        check("ovr_data", data_out, 8'hC3);

        // Byte completion coinciding with a consume: new byte wins
        loop_en = 1'b0;
        drive_frame(8'h5A, 1'b1, DONE_AT - 1, 1'b0);
        check("simul_valid", data_out_valid, 1);
        check("simul_data", data_out, 8'h5A);
        consume();
        check("simul_clear", data_out_valid, 0);
        consume();
        check("idle_ready_no_effect_valid", data_out_valid, 0);
        check("idle_ready_no_effect_data", data_out, 8'h5A);

        // Reset in the middle of a TX/RX frame
        loop_en = 1'b1;
        send_byte(8'h77);
        ticks(3 * SYM);
        rst_n = 1'b0;
        tick();
        check("midrst_serial_out", serial_out, 1);
        check("midrst_ready", data_in_ready, 0);
        check("midrst_valid", data_out_valid, 0);
        check("midrst_data", data_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_ready", data_in_ready, 1);
        check("postrst_serial_out", serial_out, 1);
        bad = 0;
        for (int k = 0; k < 12 * SYM; k++) begin
            tick();
            if (data_out_valid !== 1'b0) bad++;
        end
        check("postrst_no_valid", bad, 0);

        // Link works again after reset
        send_byte(8'hE7);
        wait_valid(12 * SYM, ok);
        check("postrst_lb_wait", ok, 1);
        check("postrst_lb_data", data_out, 8'hE7);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
